mdu_unit: RTL and testbench

Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers, sitting beside the combinational ALU in the execute stage. Accepts one operation per start pulse, holds busy for a configurable number of cycles, then commits the result to HI/LO. It adds signed/unsigned multiply, divide, multiply-accumulate and cancel-on-exception, none of which the single-cycle ALU provides.

---
 rtl/mdu_unit.sv | 143 ++++++++++++++
 tb/tb_mdu_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mdu_unit.sv
// mdu_unit: multi-cycle multiply/divide unit with architectural HI/LO registers.
// Operations are accepted in IDLE. They run for a fixed cycle count and commit to HI/LO
// on the final edge. Cancel or reset aborts an operation without a commit.
module mdu_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0]    MULN = CW'(MULT_CYCLES);
  localparam logic [CW-1:0]    DIVN = CW'(DIV_CYCLES);
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state, state_n;
  logic [CW-1:0]      cnt, cnt_n;
  logic [3:0]         rop;
  logic [WIDTH-1:0]   ra, rb;
  logic [WIDTH-1:0]   hi_n, lo_n;
  logic               done_n;
  logic               accept;

  logic [2*WIDTH-1:0] sprod, uprod, hilo, res;
  logic [WIDTH-1:0]   sq, sr, uq, ur;

  // Compute the commit value from the latched operands and the current HI/LO
  always_comb begin
    // Operands are widened to 2*WIDTH before multiplying.
    // The low 2*WIDTH bits of the product are then exact for both signed and unsigned.
    sprod = {{WIDTH{ra[WIDTH-1]}}, ra} * {{WIDTH{rb[WIDTH-1]}}, rb};
    uprod = {{WIDTH{1'b0}}, ra} * {{WIDTH{1'b0}}, rb};
    hilo  = {hi, lo};
    sq    = $signed(ra) / $signed(rb);
    sr    = $signed(ra) % $signed(rb);
    uq    = ra / rb;
    ur    = ra % rb;
    res   = hilo;
    unique case (rop)
      4'd0: res = sprod;
      4'd1: res = uprod;
      4'd6: res = hilo + sprod;
      4'd7: res = hilo - sprod;
      4'd2: begin
        if (rb == '0)                   res = {ra, {WIDTH{1'b1}}};
        else if (ra == SMIN && rb == '1) res = {{WIDTH{1'b0}}, ra};
        else                            res = {sr, sq};
      end
      4'd3: begin
        if (rb == '0) res = {ra, {WIDTH{1'b1}}};
        else          res = {ur, uq};
      end
      default: res = hilo;
    endcase
  end

  // Next-state logic: accept, count down, commit, and cancel
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    hi_n    = hi;
    lo_n    = lo;
    done_n  = 1'b0;
    accept  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !cancel) begin
          unique case (op)
            4'd0, 4'd1, 4'd6, 4'd7: begin
              accept  = 1'b1;
              cnt_n   = MULN;
              state_n = RUN;
            end
            4'd2, 4'd3: begin
              accept  = 1'b1;
              cnt_n   = DIVN;
              state_n = RUN;
            end
            4'd4:    hi_n = srca;
            4'd5:    lo_n = srca;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (cancel) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == CW'(1)) begin
          {hi_n, lo_n} = res;
          done_n       = 1'b1;
          state_n      = IDLE;
          cnt_n        = '0;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, counter, operand latch, and HI/LO registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      rop   <= '0;
      ra    <= '0;
      rb    <= '0;
      hi    <= '0;
      lo    <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      hi    <= hi_n;
      lo    <= lo_n;
      done  <= done_n;
      if (accept) begin
        rop <= op;
        ra  <= srca;
        rb  <= srcb;
      end
    end
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: scoreboard bench for mdu_unit at its default parameters.
module tb_mdu_unit;

  logic        clk = 1'b0;
  logic        rst_n, start, cancel, busy, done;
  logic [3:0]  op;
  logic [31:0] srca, srcb, hi, lo;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [63:0] sb[$];
  logic [63:0] mhl;

  mdu_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .srca(srca), .srcb(srcb),
    .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [3:0] o, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] hl);
    longint          sa, sbv, q, r;
    longint unsigned ua, ub;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    ua  = {32'h0, a};
    ub  = {32'h0, b};
    case (o)
      4'd0: return 64'(sa * sbv);
      4'd1: return ua * ub;
      4'd6: return hl + 64'(sa * sbv);
      4'd7: return hl - 64'(sa * sbv);
      4'd2: begin
        if (b == 32'h0) return {a, 32'hFFFFFFFF};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, a};
        q = sa / sbv;
        r = sa % sbv;
        return {r[31:0], q[31:0]};
      end
      4'd3: begin
        if (b == 32'h0) return {a, 32'hFFFFFFFF};
        return {32'(ua % ub), 32'(ua / ub)};
      end
      default: return hl;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept an op, scramble the operand inputs, then count busy cycles and score the commit
  task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int n, input bit poke);
    logic [63:0] e;
    int c;
    e = model(o, a, b, mhl);
    sb.push_back(e);
    mhl = e;
    start = 1'b1; op = o; srca = a; srcb = b;
    tick();
    start = 1'b0; srca = $urandom; srcb = $urandom;
    c = 0;
    while (busy && c < 200) begin
      c++;
      if (poke) begin
        start = 1'b1;
        op    = 4'(c % 8);
      end
      tick();
    end
    start = 1'b0;
    check("busy_cycles", 64'(c), 64'(n));
    check("done_pulse", {63'h0, done}, 64'h1);
    if (sb.size() > 0) check("result", {hi, lo}, sb.pop_front());
    else check("sb_empty", 64'h0, 64'h1);
    tick();
    check("done_clear", {63'h0, done}, 64'h0);
  endtask

  task automatic mt(input logic [3:0] o, input logic [31:0] v);
    start = 1'b1; op = o; srca = v;
    tick();
    start = 1'b0;
    if (o == 4'd4) mhl[63:32] = v; else mhl[31:0] = v;
    check("mt_hilo", {hi, lo}, mhl);
    check("mt_busy_done", {62'h0, busy, done}, 64'h0);
  endtask

  // Abort a MULT after 'after' idle edges; the cancel lands on the following edge
  task automatic cancel_op(input int after);
    start = 1'b1; op = 4'd0; srca = $urandom; srcb = $urandom;
    tick();
    start = 1'b0;
    repeat (after) begin
      check("cancel_done_low", {63'h0, done}, 64'h0);
      tick();
    end
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check("cancel_busy", {63'h0, busy}, 64'h0);
    check("cancel_hilo", {hi, lo}, mhl);
    check("cancel_done", {63'h0, done}, 64'h0);
    tick();
    check("cancel_done2", {63'h0, done}, 64'h0);
  endtask

  initial begin
    logic [3:0] ops[6];
    logic [3:0] o;
    ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd6, 4'd7};
    rst_n = 1'b0; start = 1'b0; cancel = 1'b0; op = '0; srca = '0; srcb = '0;
    mhl = '0;
    repeat (2) tick();
    check("reset_hilo", {hi, lo}, 64'h0);
    check("reset_busy_done", {62'h0, busy, done}, 64'h0);
    rst_n = 1'b1;
    tick();

    run_op(4'd0, 32'hFFFFFFFE, 32'd3, 5, 1'b0);
    check("mult_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFFA);
    run_op(4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 1'b1);
    check("multu_const", {hi, lo}, 64'hFFFFFFFE_00000001);
    run_op(4'd2, 32'hFFFFFFF9, 32'd2, 10, 1'b0);
    check("div_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    run_op(4'd3, 32'd7, 32'd0, 10, 1'b0);
    check("divu_zero", {hi, lo}, 64'h00000007_FFFFFFFF);
    run_op(4'd2, 32'h80000000, 32'hFFFFFFFF, 10, 1'b0);
    check("div_ovf", {hi, lo}, 64'h00000000_80000000);

    mt(4'd4, 32'd1);
    mt(4'd5, 32'hFFFFFFFF);
    run_op(4'd6, 32'd1, 32'd1, 5, 1'b0);
    check("madd_const", {hi, lo}, 64'h00000002_00000000);
    run_op(4'd7, 32'd1, 32'd1, 5, 1'b0);
    check("msub_const", {hi, lo}, 64'h00000001_FFFFFFFF);

    cancel_op(2);
    cancel_op(4);

    // Reset in the middle of a divide
    start = 1'b1; op = 4'd2; srca = 32'd100; srcb = 32'd7;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    mhl = '0;
    check("rst_mid_hilo", {hi, lo}, 64'h0);
    check("rst_mid_busy", {63'h0, busy}, 64'h0);
    tick();
    check("rst_mid_done", {63'h0, done}, 64'h0);

    // Start with cancel in IDLE is ignored, including MTHI
    start = 1'b1; cancel = 1'b1; op = 4'd0; srca = 32'd5; srcb = 32'd5;
    tick();
    check("idle_cancel_busy", {63'h0, busy}, 64'h0);
    op = 4'd4; srca = 32'h55;
    tick();
    start = 1'b0; cancel = 1'b0;
    check("idle_cancel_mthi", {hi, lo}, mhl);

    for (int i = 0; i < 8; i++) begin
      o = ops[$urandom_range(0, 5)];
      run_op(o, $urandom, (i % 3 == 0) ? 32'($urandom_range(0, 3)) : $urandom,
             (o == 4'd2 || o == 4'd3) ? 10 : 5, i[0]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
